i2s_mic_rx: RTL
===============

Name: i2s_mic_rx

Overview:
- Audio front end that produces the signed 18-bit sample stream (ADATA0 / ADATARDY) consumed by the spectrogram display block.
- Acts as I2S bus master toward an external MEMS microphone (INMP441 class): generates SCK and WS, deserialises SD and emits one-cycle sample strobes.
- Runs entirely in the 90 MHz system clock domain. SCK is a divided, registered output, not a separate clock.

Parameters:
- SCK_DIV, 22, CLK cycles per SCK half-period; minimum 4. Gives fs = 90 MHz / (2*SCK_DIV*64), about 31.96 kHz at the default.
- CH_MODE, 0, channel select: 0 = left only, 1 = right only, 2 = both (strobes alternate left, right).
- DATA_BITS, 24, serial word width driven by the microphone; must be at least 18 and at most 31.

Ports:
- CLK  in  1  system clock, 90 MHz
- RST  in  1  synchronous, active-high reset
- I2S_SD  in  1  serial data from microphone; asynchronous to CLK
- I2S_SCK  out  1  bit clock, registered
- I2S_WS  out  1  word select, registered; 0 = left, 1 = right
- ADATA0  out  18  signed sample = top 18 bits of the received word; held between strobes
- ADATARDY  out  1  one-CLK strobe; ADATA0 is valid in the same cycle

Behaviour:
- Reset: I2S_SCK=0, I2S_WS=0, ADATA0=0, ADATARDY=0. Divider counter, bit counter and shift register are cleared. If reset is asserted mid-word, the partial word is discarded and no strobe is issued.
- Divider counter d runs 0..SCK_DIV-1. When d==SCK_DIV-1, d returns to 0 and SCK toggles.
  - rise_evt = toggle while SCK==0.
  - fall_evt = toggle while SCK==1.
- Bit counter b, 6 bits, increments on fall_evt and wraps from 63 to 0. I2S_WS = b[5], registered, so it changes coincident with the SCK falling edge.
- Edge timing, counting the first CLK edge after RST deasserts as edge 1:
  - SCK rises at edge SCK_DIV*(2b+1).
  - SCK falls at edge SCK_DIV*(2b+2).
- SD passes through a 2-FF synchronizer. On each rise_evt the synchronized SD bit shifts into the shift register, MSB first. The effective sample point is 2 CLK before the SCK rise, i.e. mid-bit.
- Slot bit k = b[4:0]:
  - k=0 is the I2S one-bit delay slot and is ignored.
  - k=1..18 carry word bits [DATA_BITS-1 .. DATA_BITS-18].
  - k=19..31 are ignored; the microphone tri-states them, so their value is don't-care.
- Strobe: on the rise_evt capturing k=18 of an enabled channel, the next CLK edge loads ADATA0 with the 18 captured bits and sets ADATARDY=1 for exactly one cycle.
  - Left channel: ADATARDY high after edge SCK_DIV*37+1 (edge 815 at default).
  - Right channel: ADATARDY high after edge SCK_DIV*101+1 (edge 2223 at default).
  - Frame period is 128*SCK_DIV CLK (2816 at default).
- CH_MODE=2 gives two strobes per frame, left then right. The consumer's even/odd buffer split relies on this order.
- Arithmetic: there is no rounding or extension. ADATA0 is the raw two's-complement bit slice of the word.
- The bit counter wraps 63→0 seamlessly; WS returns to 0 on the same fall_evt.
- RST asserted on the same edge as a strobe: reset wins, and ADATARDY=0 on that edge.
- SD is ignored entirely during reset.

Decomposition:
- Package audio_pkg holds:
  - SAMPLE_W=18
  - FRAME_BITS=64
  - SLOT_BITS=32
  - CH_LEFT/CH_RIGHT/CH_BOTH encodings
  - default SCK_DIV
- One sub-module, i2s_clkgen, contains the divider, the bit counter and the SCK/WS registers. It outputs rise_evt, fall_evt and b.
- The top-level i2s_mic_rx contains the synchronizer, shift register, slot decode and output registers.

Test Plan:
1. Reset release, CH_MODE=0, SCK_DIV=22, with a bench mic model driving 24'h5A5A5A on SCK falling edges -> first ADATARDY at edge 815, ADATA0=18'h16969, one cycle wide, then repeating every 2816 CLK.
2. Left word 24'h800000, right word 24'hFFFFFF, CH_MODE=2 -> strobes at edges 815 (ADATA0=18'h20000, -131072) and 2223 (ADATA0=18'h3FFFF, -1); strictly alternating left and right.
3. SCK/WS timing check over 2 frames -> SCK period 44 CLK at 50% duty; WS toggles only at SCK falling edges, every 32 SCK periods; WS=0 for bits 0..31.
4. CH_MODE=1 with left=24'h123456 and right=24'h7FFFC0 -> only right strobes (edge 2223, ADATA0=18'h1FFFF); ADATA0 unchanged elsewhere.
5. RST pulsed 1 cycle at edge 600 (mid left word) -> all outputs return to reset values; no strobe at old edge 815; next strobe at 815 cycles after the new reset release.
6. SD toggling asynchronously between SCK rises, with a glitch placed 10 CLK after a rise -> captured word unaffected; value matches the bench model's bit at the sample point.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants, channel-mode encodings and helpers for the I2S microphone front end.
package audio_pkg;

  localparam int SAMPLE_W          = 18;
  localparam int FRAME_BITS        = 64;
  localparam int SLOT_BITS         = 32;
  localparam int BIT_W             = $clog2(FRAME_BITS);
  localparam int SLOT_W            = $clog2(SLOT_BITS);
  localparam int SCK_DIV_DEFAULT   = 22;
  localparam int DATA_BITS_DEFAULT = 24;

  typedef enum logic [1:0] {
    CH_LEFT  = 2'd0,
    CH_RIGHT = 2'd1,
    CH_BOTH  = 2'd2
  } ch_mode_e;

  // True when the slot on the given side of the frame produces a sample.
  function automatic logic ch_enabled(input logic [1:0] mode, input logic is_right);
    logic en;
    case (mode)
      CH_LEFT:  en = ~is_right;
      CH_RIGHT: en = is_right;
      CH_BOTH:  en = 1'b1;
      default:  en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bus-master timing: CLK divider, registered SCK, 6-bit frame bit counter and WS.
module i2s_clkgen
  import audio_pkg::*;
#(
  parameter int SCK_DIV = SCK_DIV_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             I2S_SCK,
  output logic             I2S_WS,
  output logic             rise_evt,
  output logic             fall_evt,
  output logic [BIT_W-1:0] b
);

  localparam int               DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

  logic [DIV_W-1:0] div_r;
  logic             sck_r;
  logic [BIT_W-1:0] bit_r;
  logic             toggle_s;

  // Half-period terminal count and the SCK edge events it implies
  always_comb begin
    toggle_s = (div_r == DIV_LAST);
    rise_evt = toggle_s & ~sck_r;
    fall_evt = toggle_s & sck_r;
  end

  // Divider, SCK and bit counter; WS is the counter MSB so it moves with SCK falling
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_r <= {DIV_W{1'b0}};
      sck_r <= 1'b0;
      bit_r <= {BIT_W{1'b0}};
    end else begin
      if (toggle_s) begin
        div_r <= {DIV_W{1'b0}};
        sck_r <= ~sck_r;
      end else begin
        div_r <= div_r + DIV_W'(1);
        sck_r <= sck_r;
      end
      if (fall_evt) begin
        bit_r <= bit_r + BIT_W'(1);
      end else begin
        bit_r <= bit_r;
      end
    end
  end

  assign I2S_SCK = sck_r;
  assign I2S_WS  = bit_r[BIT_W-1];
  assign b       = bit_r;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: synchronises SD, deserialises the top 18 bits of each
// enabled slot and presents them as a held sample with a one-cycle ready strobe.
module i2s_mic_rx
  import audio_pkg::*;
#(
  parameter int SCK_DIV   = SCK_DIV_DEFAULT,
  parameter int CH_MODE   = 0,
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       I2S_SD,
  output logic                       I2S_SCK,
  output logic                       I2S_WS,
  output logic signed [SAMPLE_W-1:0] ADATA0,
  output logic                       ADATARDY
);

  localparam logic [1:0]        MODE   = 2'(CH_MODE);
  localparam logic [SLOT_W-1:0] K_LAST = SLOT_W'(SAMPLE_W);

  if ((DATA_BITS < SAMPLE_W) || (DATA_BITS > 31) || (SCK_DIV < 4)) begin : g_bad_params
    $error("i2s_mic_rx: unsupported DATA_BITS or SCK_DIV");
  end

  logic                       rise_evt_s;
  logic                       fall_evt_s;
  logic [BIT_W-1:0]           b_s;
  logic [SLOT_W-1:0]          slot_s;
  logic                       last_bit_s;
  logic                       slot_end_s;
  logic                       sd_meta_r;
  logic                       sd_sync_r;
  logic [SAMPLE_W-1:0]        shift_r;
  logic                       pend_r;
  logic signed [SAMPLE_W-1:0] adata_r;
  logic                       rdy_r;

  i2s_clkgen #(
    .SCK_DIV (SCK_DIV)
  ) u_clkgen (
    .CLK      (CLK),
    .RST      (RST),
    .I2S_SCK  (I2S_SCK),
    .I2S_WS   (I2S_WS),
    .rise_evt (rise_evt_s),
    .fall_evt (fall_evt_s),
    .b        (b_s)
  );

  // Slot decode: the last captured word bit of an enabled channel, and the slot boundary
  always_comb begin
    slot_s     = b_s[SLOT_W-1:0];
    last_bit_s = rise_evt_s && (slot_s == K_LAST) && ch_enabled(MODE, b_s[BIT_W-1]);
    slot_end_s = fall_evt_s && (slot_s == {SLOT_W{1'b1}});
  end

  // SD synchroniser, MSB-first shift register and sample/strobe output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      sd_meta_r <= 1'b0;
      sd_sync_r <= 1'b0;
      shift_r   <= {SAMPLE_W{1'b0}};
      pend_r    <= 1'b0;
      adata_r   <= {SAMPLE_W{1'b0}};
      rdy_r     <= 1'b0;
    end else begin
      sd_meta_r <= I2S_SD;
      sd_sync_r <= sd_meta_r;
      // Slots 1..18 are the last 18 shifts before the strobe, so later bits never reach ADATA0
      if (rise_evt_s) begin
        shift_r <= {shift_r[SAMPLE_W-2:0], sd_sync_r};
      end else if (slot_end_s) begin
        shift_r <= {SAMPLE_W{1'b0}};
      end else begin
        shift_r <= shift_r;
      end
      pend_r <= last_bit_s;
      rdy_r  <= pend_r;
      if (pend_r) begin
        adata_r <= shift_r;
      end else begin
        adata_r <= adata_r;
      end
    end
  end

  assign ADATA0   = adata_r;
  assign ADATARDY = rdy_r;

endmodule
